sum_accumulator: RTL



---
 rtl/sum_accumulator.sv | 113 +++++++++++
 1 files changed

// File: rtl/sum_accumulator.sv
// Block accumulator for the signed adder output stream: sums COUNT samples, then
// rounds, shifts, saturates and presents one result per block on a registered output.
module sum_accumulator #(
  parameter int unsigned IN_W  = 29,
  parameter int unsigned COUNT = 16,
  parameter int unsigned SHIFT = 4,
  parameter int unsigned OUT_W = 29
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sat
);

  localparam int unsigned CNT_W = $clog2(COUNT);
  localparam int unsigned ACC_W = IN_W + CNT_W;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(COUNT - 1);
  localparam logic signed [ACC_W:0] Rnd = (SHIFT == 0) ? '0 :
      ({{ACC_W{1'b0}}, 1'b1} << ((SHIFT == 0) ? 0 : SHIFT - 1));
  // Clip bounds sign-extended to the rounding width.
  localparam logic signed [ACC_W:0] OutMax = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] OutMin = {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;
  logic                    out_valid_q, out_valid_d;

  logic                    last;
  logic                    accept;
  logic signed [ACC_W-1:0] total;
  logic signed [ACC_W:0]   rnd_sum;
  logic signed [ACC_W:0]   shifted;
  logic                    sat_hi;
  logic                    sat_lo;

  assign last   = (cnt_q == CntLast);
  assign accept = in_valid && in_ready;

  always_comb begin
    in_ready = !clear && !(last && out_valid_q && !out_ready);
  end

  always_comb begin
    total   = acc_q + {{(ACC_W - IN_W){in_data[IN_W-1]}}, in_data};
    rnd_sum = {total[ACC_W-1], total} + Rnd;
    shifted = rnd_sum >>> SHIFT;
    sat_hi  = (shifted > OutMax);
    sat_lo  = (shifted < OutMin);
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      if (last) begin
        acc_d       = '0;
        cnt_d       = '0;
        out_valid_d = 1'b1;
        out_sat_d   = sat_hi || sat_lo;
        if (sat_hi) begin
          out_data_d = OutMax[OUT_W-1:0];
        end else if (sat_lo) begin
          out_data_d = OutMin[OUT_W-1:0];
        end else begin
          out_data_d = shifted[OUT_W-1:0];
        end
      end else begin
        acc_d = total;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_valid = out_valid_q;

endmodule
